// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Groups the decode->issue op channel and the issue->ALU op channel.
//   master : upstream/downstream environment (drives ops, out_ready)
//   slave  : the issue stage (drives in_ready and the registered ALU operands)
//   Signals:
//     in_valid/in_ready     decode handshake
//     in_sel, in_rs1/2, in_rs1/2_data, in_imm, in_use_imm, in_rd, in_wb_en
//     out_valid/out_ready   ALU handshake
//     alu_a, alu_b, alu_sel, out_rd, out_wb_en, out_illegal, out_div_zero
interface alu_issue_stage_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_sel;
  logic [REG_BITS-1:0] in_rs1;
  logic [REG_BITS-1:0] in_rs2;
  logic [WIDTH-1:0]    in_rs1_data;
  logic [WIDTH-1:0]    in_rs2_data;
  logic [WIDTH-1:0]    in_imm;
  logic                in_use_imm;
  logic [REG_BITS-1:0] in_rd;
  logic                in_wb_en;

  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [2:0]          alu_sel;
  logic [REG_BITS-1:0] out_rd;
  logic                out_wb_en;
  logic                out_illegal;
  logic                out_div_zero;

  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd, in_wb_en, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_sel, out_rd, out_wb_en,
           out_illegal, out_div_zero
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd, in_wb_en, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_sel, out_rd, out_wb_en,
           out_illegal, out_div_zero
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX register directly upstream of the ALU. Captures one decoded op per
//   cycle, resolves operand forwarding from EX/MEM and MEM/WB, flags illegal
//   selects and divide-by-zero, and counts backpressure cycles.
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     flush           squash the held op and block capture this cycle
//     bus             op channels (alu_issue_stage_if.slave)
//     exmem_*         EX/MEM writeback bypass (wb_en, rd, data)
//     memwb_*         MEM/WB writeback bypass (wb_en, rd, data)
//     stall_cnt       saturating count of out_valid && !out_ready cycles
module alu_issue_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  alu_issue_stage_if.slave    bus,
  input  logic                exmem_wb_en,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]    exmem_data,
  input  logic                memwb_wb_en,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    memwb_data,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam logic [2:0] SEL_DIV = 3'b011;
  localparam logic [2:0] SEL_MOD = 3'b100;

  logic                valid_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [2:0]          sel_q;
  logic [REG_BITS-1:0] rd_q;
  logic                wb_en_q;
  logic                illegal_q;
  logic                div_zero_q;
  logic [CNT_BITS-1:0] stall_q;

  logic                in_ready;
  logic                capture;
  logic [WIDTH-1:0]    fwd_a;
  logic [WIDTH-1:0]    fwd_b;
  logic [WIDTH-1:0]    b_next;
  logic                illegal_next;
  logic                div_zero_next;

  assign in_ready = !valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready && !flush;

  // EX/MEM is younger than MEM/WB, so it wins when both target the source.
  always_comb begin
    fwd_a = bus.in_rs1_data;
    if (bus.in_rs1 == '0)
      fwd_a = '0;
    else if (exmem_wb_en && exmem_rd == bus.in_rs1)
      fwd_a = exmem_data;
    else if (memwb_wb_en && memwb_rd == bus.in_rs1)
      fwd_a = memwb_data;
  end

  always_comb begin
    fwd_b = bus.in_rs2_data;
    if (bus.in_rs2 == '0)
      fwd_b = '0;
    else if (exmem_wb_en && exmem_rd == bus.in_rs2)
      fwd_b = exmem_data;
    else if (memwb_wb_en && memwb_rd == bus.in_rs2)
      fwd_b = memwb_data;
  end

  always_comb begin
    b_next        = bus.in_use_imm ? bus.in_imm : fwd_b;
    illegal_next  = (bus.in_sel > SEL_MOD);
    div_zero_next = ((bus.in_sel == SEL_DIV) || (bus.in_sel == SEL_MOD)) &&
                    (b_next == '0);
  end

  // Operand registers only load on capture, so a held op stays frozen and
  // forwarding is never re-evaluated against newer bypass values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 3'b000;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      if (valid_q && !bus.out_ready && stall_q != {CNT_BITS{1'b1}})
        stall_q <= stall_q + CNT_BITS'(1);

      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q    <= 1'b1;
        a_q        <= fwd_a;
        b_q        <= b_next;
        sel_q      <= bus.in_sel;
        rd_q       <= bus.in_rd;
        wb_en_q    <= bus.in_wb_en && !illegal_next;
        illegal_q  <= illegal_next;
        div_zero_q <= div_zero_next;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_sel      = sel_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_wb_en    = wb_en_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.out_div_zero = div_zero_q;
  assign stall_cnt        = stall_q;

endmodule
